// File: rtl/kf_choir_consensus_v2.sv
// kf_choir_consensus_v2: weighted-majority consensus over N_LANES lane beats.
// Two-stage pipeline (W1 per bit, then result/margin) with stall-all backpressure,
// stream-level low-confidence counter and a held summary handshake.
// Optional per-lane dissent counters: define KF_CHOIR_LANE_STATS_EN.
module kf_choir_consensus_v2 #(
    parameter int N_LANES  = 16,
    parameter int BEAT_W   = 8,
    parameter int WEIGHT_W = 4,
    parameter int CNT_W    = 14,
    localparam int SUM_W   = $clog2(N_LANES * (2 ** WEIGHT_W - 1) + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [N_LANES*BEAT_W-1:0]   lane_bits,
    input  logic [N_LANES-1:0]          lane_mask,
    input  logic [N_LANES*WEIGHT_W-1:0] lane_weight,
    input  logic                        tie_one,
    input  logic [SUM_W-1:0]            margin_thresh,
    input  logic [CNT_W-1:0]            escalate_limit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BEAT_W-1:0]           out_bits,
    output logic [SUM_W-1:0]            out_min_margin,
    output logic                        out_last,
    output logic                        sum_valid,
    input  logic                        sum_ready,
    output logic [CNT_W-1:0]            sum_low_conf,
    output logic                        sum_escalate,
    output logic                        busy,
    output logic [N_LANES*CNT_W-1:0]    lane_dissent
);

    localparam int POP_W = $clog2(BEAT_W + 1);

    typedef enum logic [1:0] {StIdle, StStream, StDrain, StSummary} state_e;

    state_e                      state_q, state_d;
    logic [N_LANES-1:0]          mask_q;
    logic [N_LANES*WEIGHT_W-1:0] weight_q;
    logic                        tie_q;

    logic stall, advance, accept, first_beat;
    logic [N_LANES-1:0]          cfg_mask;
    logic [N_LANES*WEIGHT_W-1:0] cfg_weight;

    logic [SUM_W-1:0] w1_d [BEAT_W];
    logic [SUM_W-1:0] s1_w1_q [BEAT_W];
    logic             s1_valid_q, s1_last_q;

    logic [SUM_W-1:0]  wt;
    logic [BEAT_W-1:0] res_d;
    logic [SUM_W-1:0]  min_d;
    logic [POP_W-1:0]  lowpop_d;

    logic              out_valid_q, out_last_q;
    logic [BEAT_W-1:0] out_bits_q;
    logic [SUM_W-1:0]  out_min_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W:0]    cnt_sum;

    assign stall      = out_valid_q && !out_ready;
    assign advance    = !stall;
    assign in_ready   = rst_n && !stall && (state_q == StIdle || state_q == StStream);
    assign accept     = in_valid && in_ready;
    assign first_beat = accept && (state_q == StIdle);

    // The first beat of a stream is processed with the config it presents.
    assign cfg_mask   = (state_q == StIdle) ? lane_mask : mask_q;
    assign cfg_weight = (state_q == StIdle) ? lane_weight : weight_q;

    // Stage-1 input: weighted sum of masked lanes voting 1, per bit.
    always_comb begin
        for (int b = 0; b < BEAT_W; b++) begin
            w1_d[b] = '0;
            for (int l = 0; l < N_LANES; l++) begin
                if (cfg_mask[l] && lane_bits[l*BEAT_W+b]) begin
                    w1_d[b] = w1_d[b] + SUM_W'(cfg_weight[l*WEIGHT_W +: WEIGHT_W]);
                end
            end
        end
    end

    // Stage-2 input: total weight, per-bit result/margin, min margin, low-confidence popcount.
    always_comb begin : stage2_comb
        logic [SUM_W:0]   two_w1;
        logic [SUM_W:0]   wt_x;
        logic [SUM_W:0]   diff;
        logic [SUM_W-1:0] mrg;
        wt = '0;
        for (int l = 0; l < N_LANES; l++) begin
            if (mask_q[l]) wt = wt + SUM_W'(weight_q[l*WEIGHT_W +: WEIGHT_W]);
        end
        res_d    = '0;
        min_d    = '1;
        lowpop_d = '0;
        wt_x     = {1'b0, wt};
        for (int b = 0; b < BEAT_W; b++) begin
            two_w1 = {s1_w1_q[b], 1'b0};
            if (two_w1 > wt_x) begin
                res_d[b] = 1'b1;
                diff     = two_w1 - wt_x;
            end else if (two_w1 < wt_x) begin
                res_d[b] = 1'b0;
                diff     = wt_x - two_w1;
            end else begin
                res_d[b] = tie_q;
                diff     = '0;
            end
            // No voting weight at all: force a 0 that is always low-confidence.
            if (wt == '0) begin
                res_d[b] = 1'b0;
                diff     = '0;
            end
            mrg = diff[SUM_W-1:0];
            if (mrg < min_d) min_d = mrg;
            if (wt == '0 || mrg < margin_thresh) lowpop_d = lowpop_d + POP_W'(1);
        end
    end

    // Saturating low-confidence accumulation.
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(lowpop_d);
        cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    // Stream FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = in_last ? StDrain : StStream;
            StStream:  if (accept && in_last) state_d = StDrain;
            StDrain:   if (out_valid_q && out_ready && out_last_q) state_d = StSummary;
            StSummary: if (sum_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State, latched config, pipeline stages and the stream counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            weight_q    <= '0;
            tie_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_w1_q     <= '{default: '0};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_bits_q  <= '0;
            out_min_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;
            if (first_beat) begin
                mask_q   <= lane_mask;
                weight_q <= lane_weight;
                tie_q    <= tie_one;
            end
            if (advance) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_w1_q   <= w1_d;
                    s1_last_q <= in_last;
                end
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_bits_q <= res_d;
                    out_min_q  <= min_d;
                    out_last_q <= s1_last_q;
                end
            end
            if (first_beat) begin
                cnt_q <= '0;
            end else if (advance && s1_valid_q) begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_bits       = out_bits_q;
    assign out_min_margin = out_min_q;
    assign out_last       = out_last_q;
    assign sum_valid      = (state_q == StSummary);
    assign sum_low_conf   = cnt_q;
    assign sum_escalate   = (cnt_q > escalate_limit);
    assign busy           = (state_q != StIdle);

`ifdef KF_CHOIR_LANE_STATS_EN
    logic [N_LANES*BEAT_W-1:0] s1_lanes_q, s2_lanes_q;
    logic [CNT_W-1:0]          dissent_q [N_LANES];
    logic [CNT_W-1:0]          dissent_d [N_LANES];

    // Per-lane saturating dissent against the beat currently leaving stage 2.
    always_comb begin : dissent_comb
        logic [POP_W-1:0] pop;
        logic [CNT_W:0]   acc;
        for (int l = 0; l < N_LANES; l++) begin
            pop = '0;
            for (int b = 0; b < BEAT_W; b++) begin
                pop = pop + POP_W'(s2_lanes_q[l*BEAT_W+b] ^ out_bits_q[b]);
            end
            acc          = {1'b0, dissent_q[l]} + (CNT_W+1)'(pop);
            dissent_d[l] = acc[CNT_W] ? '1 : acc[CNT_W-1:0];
        end
    end

    // Lane bits ride alongside the pipeline; counters update on output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_lanes_q <= '0;
            s2_lanes_q <= '0;
            dissent_q  <= '{default: '0};
        end else begin
            if (accept) s1_lanes_q <= lane_bits;
            if (advance && s1_valid_q) s2_lanes_q <= s1_lanes_q;
            if (first_beat) begin
                dissent_q <= '{default: '0};
            end else if (out_valid_q && out_ready) begin
                for (int l = 0; l < N_LANES; l++) begin
                    if (mask_q[l]) dissent_q[l] <= dissent_d[l];
                end
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        for (int l = 0; l < N_LANES; l++) lane_dissent[l*CNT_W +: CNT_W] = dissent_q[l];
    end
`else
    assign lane_dissent = '0;
`endif

endmodule

// File: tb/tb_kf_choir_consensus_v2.sv
// Directed bench for kf_choir_consensus_v2 (default parameters).
module tb_kf_choir_consensus_v2;

    localparam int N_LANES  = 16;
    localparam int BEAT_W   = 8;
    localparam int WEIGHT_W = 4;
    localparam int CNT_W    = 14;
    localparam int SUM_W    = 8;
    localparam int LB_W     = N_LANES * BEAT_W;

    logic                        clk;
    logic                        rst_n;
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_last;
    logic [LB_W-1:0]             lane_bits;
    logic [N_LANES-1:0]          lane_mask;
    logic [N_LANES*WEIGHT_W-1:0] lane_weight;
    logic                        tie_one;
    logic [SUM_W-1:0]            margin_thresh;
    logic [CNT_W-1:0]            escalate_limit;
    logic                        out_valid;
    logic                        out_ready;
    logic [BEAT_W-1:0]           out_bits;
    logic [SUM_W-1:0]            out_min_margin;
    logic                        out_last;
    logic                        sum_valid;
    logic                        sum_ready;
    logic [CNT_W-1:0]            sum_low_conf;
    logic                        sum_escalate;
    logic                        busy;
    logic [N_LANES*CNT_W-1:0]    lane_dissent;

    kf_choir_consensus_v2 #(
        .N_LANES (N_LANES),
        .BEAT_W  (BEAT_W),
        .WEIGHT_W(WEIGHT_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_last       (in_last),
        .lane_bits     (lane_bits),
        .lane_mask     (lane_mask),
        .lane_weight   (lane_weight),
        .tie_one       (tie_one),
        .margin_thresh (margin_thresh),
        .escalate_limit(escalate_limit),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_bits      (out_bits),
        .out_min_margin(out_min_margin),
        .out_last      (out_last),
        .sum_valid     (sum_valid),
        .sum_ready     (sum_ready),
        .sum_low_conf  (sum_low_conf),
        .sum_escalate  (sum_escalate),
        .busy          (busy),
        .lane_dissent  (lane_dissent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [BEAT_W-1:0] got_bits_q [$];
    logic [SUM_W-1:0]  got_mrg_q  [$];
    logic              got_last_q [$];
    logic [BEAT_W-1:0] exp_bits_q [$];
    logic [LB_W-1:0]   lb;
    int                exp_d3;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Record every output handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_bits_q.push_back(out_bits);
            got_mrg_q.push_back(out_min_margin);
            got_last_q.push_back(out_last);
        end
    end

    function automatic logic [LB_W-1:0] fill(input logic [BEAT_W-1:0] p);
        logic [LB_W-1:0] v;
        for (int l = 0; l < N_LANES; l++) v[l*BEAT_W +: BEAT_W] = p;
        return v;
    endfunction

    task automatic set_cfg(input logic [N_LANES-1:0] m, input logic [63:0] w, input logic t,
                           input logic [SUM_W-1:0] thr, input logic [CNT_W-1:0] lim);
        lane_mask      = m;
        lane_weight    = w;
        tie_one        = t;
        margin_thresh  = thr;
        escalate_limit = lim;
    endtask

    task automatic drive_beat(input logic [LB_W-1:0] bits, input logic last);
        bit done = 0;
        lane_bits = bits;
        in_last   = last;
        in_valid  = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) check_val("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic finish_summary(input string tag, input logic [CNT_W-1:0] exp_low,
                                  input logic exp_esc, input int hold);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (sum_valid) seen = 1;
        end
        if (!seen) begin
            check_val({tag, "_sum_timeout"}, 64'(0), 64'(1));
        end else begin
            check_val({tag, "_low_conf"}, 64'(sum_low_conf), 64'(exp_low));
            check_val({tag, "_escalate"}, 64'(sum_escalate), 64'(exp_esc));
            for (int i = 0; i < hold; i++) @(negedge clk);
            if (hold > 0) check_val({tag, "_sum_held"}, 64'(sum_valid), 64'(1));
            @(posedge clk);
            #1;
            sum_ready = 1'b1;
            @(posedge clk);
            #1;
            sum_ready = 1'b0;
            check_val({tag, "_idle_busy"}, 64'(busy), 64'(0));
            check_val({tag, "_idle_sum_valid"}, 64'(sum_valid), 64'(0));
        end
    endtask

    task automatic check_outputs(input string tag, input logic [SUM_W-1:0] mg);
        int n;
        n = exp_bits_q.size();
        check_val({tag, "_count"}, 64'(got_bits_q.size()), 64'(n));
        for (int i = 0; i < n && i < got_bits_q.size(); i++) begin
            check_val($sformatf("%s_bits%0d", tag, i), 64'(got_bits_q[i]), 64'(exp_bits_q[i]));
            check_val($sformatf("%s_margin%0d", tag, i), 64'(got_mrg_q[i]), 64'(mg));
            check_val($sformatf("%s_last%0d", tag, i), 64'(got_last_q[i]), 64'(i == n - 1));
        end
        got_bits_q.delete();
        got_mrg_q.delete();
        got_last_q.delete();
        exp_bits_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check_val({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check_val({tag, "_out_bits"}, 64'(out_bits), 64'(0));
        check_val({tag, "_out_margin"}, 64'(out_min_margin), 64'(0));
        check_val({tag, "_out_last"}, 64'(out_last), 64'(0));
        check_val({tag, "_sum_valid"}, 64'(sum_valid), 64'(0));
        check_val({tag, "_low_conf"}, 64'(sum_low_conf), 64'(0));
        check_val({tag, "_escalate"}, 64'(sum_escalate), 64'(0));
        check_val({tag, "_busy"}, 64'(busy), 64'(0));
        check_val({tag, "_dissent_zero"}, 64'(lane_dissent == '0), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        lane_bits = '0;
        out_ready = 1'b1;
        sum_ready = 1'b0;
        set_cfg('1, {16{4'h1}}, 1'b0, 8'd2, 14'd0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        #1;
        check_val("post_reset_in_ready", 64'(in_ready), 64'(1));

        // Unanimous 0xA5, four beats; check two-cycle latency.
        set_cfg('1, {16{4'h1}}, 1'b0, 8'd2, 14'd0);
        @(posedge clk);
        #1;
        drive_beat(fill(8'hA5), 1'b0);
        check_val("t1_lat_s1", 64'(out_valid), 64'(0));
        drive_beat(fill(8'hA5), 1'b0);
        check_val("t1_lat_s2", 64'(out_valid), 64'(1));
        drive_beat(fill(8'hA5), 1'b0);
        drive_beat(fill(8'hA5), 1'b1);
        for (int i = 0; i < 4; i++) exp_bits_q.push_back(8'hA5);
        finish_summary("t1", 14'd0, 1'b0, 0);
        check_outputs("t1", 8'd16);

        // Even split, tie_one=1, single beat; escalate 8 > 7.
        set_cfg('1, {16{4'h1}}, 1'b1, 8'd2, 14'd7);
        lb = '0;
        for (int l = 0; l < 8; l++) lb[l*BEAT_W +: BEAT_W] = 8'hFF;
        drive_beat(lb, 1'b1);
        exp_bits_q.push_back(8'hFF);
        finish_summary("t2", 14'd8, 1'b1, 0);
        check_outputs("t2", 8'd0);

        // Weighted tie: W1=15, WT=30, tie_one=0; 8 > 8 does not escalate.
        lb = '0;
        lb[BEAT_W-1:0] = 8'hFF;
        set_cfg('1, {{15{4'h1}}, 4'hF}, 1'b0, 8'd1, 14'd8);
        drive_beat(lb, 1'b1);
        exp_bits_q.push_back(8'h00);
        finish_summary("t3a", 14'd8, 1'b0, 0);
        check_outputs("t3a", 8'd0);

        // Lane 15 masked out: WT=29, result 1, margin 1 (not below threshold 1).
        set_cfg(16'h7FFF, {{15{4'h1}}, 4'hF}, 1'b0, 8'd1, 14'd0);
        drive_beat(lb, 1'b1);
        exp_bits_q.push_back(8'hFF);
        finish_summary("t3b", 14'd0, 1'b0, 0);
        check_outputs("t3b", 8'd1);

        // Backpressure: out_ready low for five cycles mid-stream.
        set_cfg('1, {16{4'h1}}, 1'b0, 8'd2, 14'd0);
        drive_beat(fill(8'h01), 1'b0);
        drive_beat(fill(8'h02), 1'b0);
        out_ready = 1'b0;
        lane_bits = fill(8'h03);
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_val($sformatf("t4_stall_in_ready%0d", c), 64'(in_ready), 64'(0));
            check_val($sformatf("t4_stall_out_valid%0d", c), 64'(out_valid), 64'(1));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 3; i <= 6; i++) drive_beat(fill(BEAT_W'(i)), i == 6);
        for (int i = 1; i <= 6; i++) exp_bits_q.push_back(BEAT_W'(i));
        finish_summary("t4", 14'd0, 1'b0, 3);
        check_outputs("t4", 8'd16);

        // Empty mask: forced 0 (despite tie_one), every bit low-confidence even at threshold 0.
        set_cfg('0, {16{4'h1}}, 1'b1, 8'd0, 14'd23);
        drive_beat(fill(8'hFF), 1'b0);
        drive_beat(fill(8'h0F), 1'b0);
        drive_beat(fill(8'h3C), 1'b1);
        for (int i = 0; i < 3; i++) exp_bits_q.push_back(8'h00);
        finish_summary("t5", 14'd24, 1'b1, 0);
        check_outputs("t5", 8'd0);

        // Reset mid-stream, then a clean stream.
        set_cfg('1, {16{4'h1}}, 1'b0, 8'd2, 14'd0);
        drive_beat(fill(8'h11), 1'b0);
        drive_beat(fill(8'h22), 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_state("midrst");
        repeat (2) @(posedge clk);
        #1;
        got_bits_q.delete();
        got_mrg_q.delete();
        got_last_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_beat(fill(8'h5A), 1'b0);
        drive_beat(fill(8'h5A), 1'b1);
        exp_bits_q.push_back(8'h5A);
        exp_bits_q.push_back(8'h5A);
        finish_summary("t6", 14'd0, 1'b0, 0);
        check_outputs("t6", 8'd16);

        // Lane 3 inverted against the rest for ten beats.
        set_cfg('1, {16{4'h1}}, 1'b0, 8'd2, 14'd0);
        lb = fill(8'h3C);
        lb[3*BEAT_W +: BEAT_W] = 8'hC3;
        for (int i = 0; i < 10; i++) drive_beat(lb, i == 9);
        for (int i = 0; i < 10; i++) exp_bits_q.push_back(8'h3C);
        finish_summary("t7", 14'd0, 1'b0, 0);
        check_outputs("t7", 8'd14);
`ifdef KF_CHOIR_LANE_STATS_EN
        exp_d3 = 80;
`else
        exp_d3 = 0;
`endif
        check_val("t7_dissent_lane3", 64'(lane_dissent[3*CNT_W +: CNT_W]), 64'(exp_d3));
        check_val("t7_dissent_lane0", 64'(lane_dissent[0 +: CNT_W]), 64'(0));
        check_val("t7_dissent_lane15", 64'(lane_dissent[15*CNT_W +: CNT_W]), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
